// File: rtl/ifu_ibuf_pkg.sv
// Shared fetch-side constants and the instruction buffer entry layout.
// Imported by the fetch buffer and anything that talks to it.
package ifu_ibuf_pkg;

    localparam int INST_ADDR_WIDTH = 32;
    localparam int INST_DATA_WIDTH = 32;

    localparam logic [INST_DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

    localparam int IBUF_DEPTH = 4;
    localparam logic [INST_ADDR_WIDTH-1:0] IBUF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [INST_ADDR_WIDTH-1:0] pc;
        logic [INST_DATA_WIDTH-1:0] data;
        logic                       filled;
    } ibuf_entry_t;

endpackage

// File: rtl/ifu_ibuf.sv
// Instruction fetch buffer: sequential bus fetch, in-order entry queue,
// flush/redirect on jump with counted discard of stale responses.
module ifu_ibuf
    import ifu_ibuf_pkg::*;
#(
    parameter int                         DEPTH    = IBUF_DEPTH,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC = IBUF_RESET_PC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       jump_flag_i,
    input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
    output logic                       ibus_req_o,
    output logic [INST_ADDR_WIDTH-1:0] ibus_addr_o,
    input  logic                       ibus_gnt_i,
    input  logic                       ibus_rvalid_i,
    input  logic [INST_DATA_WIDTH-1:0] ibus_rdata_i,
    output logic                       inst_valid_o,
    output logic [INST_DATA_WIDTH-1:0] inst_o,
    output logic [INST_ADDR_WIDTH-1:0] inst_addr_o,
    input  logic                       inst_ready_i
);

    localparam int PW = $clog2(DEPTH);

    typedef logic [PW:0] ptr_t;

    localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

    logic [INST_ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    ptr_t                       alloc_ptr_q, alloc_ptr_d;
    ptr_t                       fill_ptr_q, fill_ptr_d;
    ptr_t                       rd_ptr_q, rd_ptr_d;
    ptr_t                       discard_cnt_q, discard_cnt_d;
    ibuf_entry_t                ent_q [DEPTH];
    ibuf_entry_t                ent_d [DEPTH];

    ptr_t          used;
    ptr_t          busy;
    ptr_t          outst;
    logic [PW-1:0] head_idx;
    logic [PW-1:0] alloc_idx;
    logic [PW-1:0] fill_idx;
    logic          grant;
    logic          pop;
    logic          resp_drop;
    logic          resp_keep;
    logic          unused_jaddr;

    assign unused_jaddr = ^jump_addr_i[1:0];

    assign head_idx  = rd_ptr_q[PW-1:0];
    assign alloc_idx = alloc_ptr_q[PW-1:0];
    assign fill_idx  = fill_ptr_q[PW-1:0];

    // Stale responses still hold bus slots, so they consume credit too.
    assign used  = alloc_ptr_q - rd_ptr_q;
    assign busy  = used + discard_cnt_q;
    assign outst = (alloc_ptr_q - fill_ptr_q) + discard_cnt_q;

    assign ibus_req_o  = ~rst & ~jump_flag_i & (busy < DEPTH_P);
    assign ibus_addr_o = fetch_pc_q;
    assign grant       = ibus_req_o & ibus_gnt_i;

    assign inst_valid_o = ~rst & ent_q[head_idx].filled
                          & (rd_ptr_q != alloc_ptr_q);
    assign inst_o       = inst_valid_o ? ent_q[head_idx].data : INST_NOP;
    assign inst_addr_o  = inst_valid_o ? ent_q[head_idx].pc : '0;
    assign pop          = inst_valid_o & inst_ready_i;

    assign resp_drop = ibus_rvalid_i & (discard_cnt_q != '0);
    assign resp_keep = ibus_rvalid_i & (discard_cnt_q == '0)
                       & (fill_ptr_q != alloc_ptr_q);

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        alloc_ptr_d   = alloc_ptr_q;
        fill_ptr_d    = fill_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        discard_cnt_d = discard_cnt_q;
        ent_d         = ent_q;

        if (jump_flag_i) begin
            fetch_pc_d  = {jump_addr_i[INST_ADDR_WIDTH-1:2], 2'b00};
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i].filled = 1'b0;
            end
            // A response landing in the flush cycle retires one stale slot.
            discard_cnt_d = outst
                - ptr_t'(ibus_rvalid_i & (outst != '0));
        end else begin
            if (grant) begin
                ent_d[alloc_idx].pc     = fetch_pc_q;
                ent_d[alloc_idx].filled = 1'b0;
                alloc_ptr_d             = alloc_ptr_q + ptr_t'(1);
                fetch_pc_d              = fetch_pc_q + 32'd4;
            end
            if (resp_drop) begin
                discard_cnt_d = discard_cnt_q - ptr_t'(1);
            end
            if (resp_keep) begin
                ent_d[fill_idx].data   = ibus_rdata_i;
                ent_d[fill_idx].filled = 1'b1;
                fill_ptr_d             = fill_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                ent_d[head_idx].filled = 1'b0;
                rd_ptr_d               = rd_ptr_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            alloc_ptr_q   <= '0;
            fill_ptr_q    <= '0;
            rd_ptr_q      <= '0;
            discard_cnt_q <= '0;
            ent_q         <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            alloc_ptr_q   <= alloc_ptr_d;
            fill_ptr_q    <= fill_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            discard_cnt_q <= discard_cnt_d;
            ent_q         <= ent_d;
        end
    end

    // A response with nothing outstanding is a bus protocol violation.
    rvalid_has_owner: assert property (
        @(posedge clk) disable iff (rst)
        ibus_rvalid_i |-> (outst != '0)
    );

endmodule

// File: tb/tb_ifu_ibuf.sv
// Bench for the fetch buffer: directed scenarios plus a randomized bus
// and decoder, checked against an in-order program-stream scoreboard.
module tb_ifu_ibuf;
    import ifu_ibuf_pkg::*;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat_min = 1;
    int lat_max = 1;
    int pops = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] sbq[$];
    logic [31:0] mpc;

    ifu_ibuf #(.DEPTH(4), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .ibus_req_o   (ibus_req),
        .ibus_addr_o  (ibus_addr),
        .ibus_gnt_i   (ibus_gnt),
        .ibus_rvalid_i(ibus_rvalid),
        .ibus_rdata_i (ibus_rdata),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr),
        .inst_ready_i (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    // Memory: in-order responses, per-request latency in [lat_min, lat_max].
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ibus_rvalid = 1'b1;
            ibus_rdata  = memf(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            ibus_rvalid = 1'b0;
            ibus_rdata  = $urandom;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend.delete();
        end else if (ibus_req && ibus_gnt) begin
            pend.push_back('{ibus_addr,
                cyc + int'($urandom_range(lat_min, lat_max))});
        end
    end

    // Scoreboard: each grant queues the PC the program stream expects.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_valid", 32'(inst_valid), 32'd0);
            chk("rst_inst", inst, INST_NOP);
            chk("rst_req", 32'(ibus_req), 32'd0);
            sbq.delete();
            mpc = RPC;
        end else begin
            if (!inst_valid) begin
                chk("idle_inst", inst, INST_NOP);
                chk("idle_addr", inst_addr, 32'd0);
            end
            if (jump_flag) begin
                chk("flush_req", 32'(ibus_req), 32'd0);
                sbq.delete();
                mpc = {jump_addr[31:2], 2'b00};
            end else begin
                if (inst_valid && inst_ready) begin
                    chk("pop_sb_empty", 32'(sbq.size() == 0), 32'd0);
                    if (sbq.size() > 0) begin
                        chk("pop_pc", inst_addr, sbq[0]);
                        chk("pop_data", inst, memf(sbq[0]));
                        void'(sbq.pop_front());
                    end
                    pops++;
                end
                if (ibus_req && ibus_gnt) begin
                    chk("req_addr", ibus_addr, mpc);
                    sbq.push_back(mpc);
                    mpc = mpc + 32'd4;
                end
            end
        end
    end

    task automatic nc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic wait_valid(input int lim, output int k);
        k = 0;
        while (!inst_valid && k < lim) begin
            nc();
            smp();
            k++;
        end
    endtask

    initial begin
        int n;
        int k;
        rst        = 1'b1;
        jump_flag  = 1'b0;
        jump_addr  = '0;
        ibus_gnt   = 1'b1;
        inst_ready = 1'b1;
        ibus_rvalid = 1'b0;
        ibus_rdata = '0;

        // Reset and streaming with 1-cycle memory
        smp();
        chk("t1_rst_req", 32'(ibus_req), 32'd0);
        nc();
        nc();
        rst = 1'b0;
        smp();
        chk("t1_first_req", 32'(ibus_req), 32'd1);
        chk("t1_first_addr", ibus_addr, RPC);
        chk("t1_v0", 32'(inst_valid), 32'd0);
        nc();
        smp();
        chk("t1_addr1", ibus_addr, 32'h4);
        chk("t1_v1", 32'(inst_valid), 32'd0);
        nc();
        smp();
        chk("t1_v2", 32'(inst_valid), 32'd1);
        chk("t1_head_pc", inst_addr, 32'h0);
        for (int i = 0; i < 8; i++) begin
            nc();
            smp();
            chk("t1_thru", 32'(inst_valid), 32'd1);
        end

        // Backpressure until full, then a single pop
        nc();
        rst = 1'b1;
        inst_ready = 1'b0;
        smp();
        nc();
        rst = 1'b0;
        smp();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (ibus_req && ibus_gnt) n++;
            nc();
            smp();
        end
        chk("t2_grants", 32'(n), 32'd4);
        chk("t2_full_req", 32'(ibus_req), 32'd0);
        nc();
        inst_ready = 1'b1;
        smp();
        chk("t2_pop_valid", 32'(inst_valid), 32'd1);
        chk("t2_pop_req", 32'(ibus_req), 32'd0);
        nc();
        inst_ready = 1'b0;
        smp();
        chk("t2_refill_req", 32'(ibus_req), 32'd1);
        chk("t2_refill_addr", ibus_addr, 32'h10);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            if (ibus_req && ibus_gnt) n++;
            nc();
            smp();
        end
        chk("t2_one_grant", 32'(n), 32'd1);

        // Flush with three requests in flight, 4-cycle memory
        nc();
        rst = 1'b1;
        inst_ready = 1'b1;
        lat_min = 4;
        lat_max = 4;
        smp();
        nc();
        rst = 1'b0;
        smp();
        nc();
        smp();
        nc();
        smp();
        nc();
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0103;
        smp();
        chk("t3_flush_req", 32'(ibus_req), 32'd0);
        nc();
        jump_flag = 1'b0;
        smp();
        chk("t3_tgt_req", 32'(ibus_req), 32'd1);
        chk("t3_tgt_addr", ibus_addr, 32'h100);
        wait_valid(30, k);
        chk("t3_first_lat", 32'(k), 32'd5);
        chk("t3_first_pc", inst_addr, 32'h100);
        chk("t3_first_data", inst, memf(32'h100));

        // Flush coinciding with rvalid and pop, 2-cycle memory
        nc();
        rst = 1'b1;
        lat_min = 2;
        lat_max = 2;
        smp();
        nc();
        rst = 1'b0;
        smp();
        for (int i = 0; i < 8; i++) begin
            nc();
            smp();
        end
        chk("t4_steady", 32'(inst_valid), 32'd1);
        nc();
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0200;
        smp();
        chk("t4_rv_in_flush", 32'(ibus_rvalid & inst_valid), 32'd1);
        nc();
        jump_flag = 1'b0;
        smp();
        chk("t4_valid_after", 32'(inst_valid), 32'd0);
        chk("t4_tgt_req", 32'(ibus_req), 32'd1);
        chk("t4_tgt_addr", ibus_addr, 32'h200);
        wait_valid(30, k);
        chk("t4_first_lat", 32'(k), 32'd3);
        chk("t4_first_pc", inst_addr, 32'h200);

        // Grant stall
        nc();
        rst = 1'b1;
        lat_min = 1;
        lat_max = 1;
        smp();
        nc();
        rst = 1'b0;
        ibus_gnt = 1'b0;
        smp();
        for (int i = 0; i < 5; i++) begin
            chk("t5_stall_req", 32'(ibus_req), 32'd1);
            chk("t5_stall_addr", ibus_addr, RPC);
            nc();
            smp();
        end
        nc();
        ibus_gnt = 1'b1;
        smp();
        chk("t5_gnt_addr", ibus_addr, RPC);
        nc();
        ibus_gnt = 1'b0;
        smp();
        chk("t5_next_addr", ibus_addr, 32'h4);

        // Reset with the buffer full
        nc();
        ibus_gnt = 1'b1;
        inst_ready = 1'b0;
        smp();
        for (int i = 0; i < 8; i++) begin
            nc();
            smp();
        end
        chk("t6_full_valid", 32'(inst_valid), 32'd1);
        chk("t6_full_req", 32'(ibus_req), 32'd0);
        nc();
        rst = 1'b1;
        smp();
        chk("t6_rst_valid", 32'(inst_valid), 32'd0);
        chk("t6_rst_inst", inst, INST_NOP);
        nc();
        rst = 1'b0;
        inst_ready = 1'b1;
        smp();
        chk("t6_req", 32'(ibus_req), 32'd1);
        chk("t6_addr", ibus_addr, RPC);

        // Randomized bus, decoder and redirects
        lat_min = 1;
        lat_max = 4;
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            nc();
            ibus_gnt   = ($urandom_range(0, 3) != 0);
            inst_ready = ($urandom_range(0, 3) != 0);
            jump_flag  = ($urandom_range(0, 39) == 0);
            jump_addr  = $urandom;
            smp();
        end
        nc();
        jump_flag  = 1'b0;
        ibus_gnt   = 1'b0;
        inst_ready = 1'b1;
        smp();
        for (int i = 0; i < 30; i++) begin
            nc();
            smp();
        end
        chk("rnd_drained", 32'(sbq.size()), 32'd0);
        chk("rnd_progress", 32'(pops > 500), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
